// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a shared single-ported, variable-latency memory
// Optional fetch starvation guard is enabled by defining MEMARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 InstrReq,
  input  logic [WORD_SIZE-1:0] InstrAddr,
  output logic [WORD_SIZE-1:0] InstrIn,
  output logic                 InstrDone,
  input  logic                 ReadData,
  input  logic                 WriteData,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataDone,
  output logic [WORD_SIZE-1:0] MemAddr,
  output logic [WORD_SIZE-1:0] MemWData,
  output logic                 MemRead,
  output logic                 MemWrite,
  input  logic [WORD_SIZE-1:0] MemRData,
  input  logic                 MemReady
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t state;
  logic   data_pending;
  logic   grant_instr;

  assign data_pending = ReadData | WriteData;

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  // Fetch wins a contested IDLE slot once data has been granted LIMIT times in a row over it.
  assign grant_instr = InstrReq & (~data_pending | (starve_cnt == LIMIT));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_instr) begin
        starve_cnt <= '0;
      end else if (data_pending) begin
        if (!InstrReq) begin
          starve_cnt <= '0;
        end else if (starve_cnt != LIMIT) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign grant_instr = InstrReq & ~data_pending;
`endif

  // The memory command doubles as the latched operation type: MemRead low in BUSY_D means a write.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      MemAddr   <= '0;
      MemWData  <= '0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      InstrIn   <= '0;
      DataIn    <= '0;
      InstrDone <= 1'b0;
      DataDone  <= 1'b0;
    end else begin
      InstrDone <= 1'b0;
      DataDone  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_instr) begin
            state    <= BUSY_I;
            MemAddr  <= InstrAddr;
            MemWData <= '0;
            MemRead  <= 1'b1;
            MemWrite <= 1'b0;
          end else if (data_pending) begin
            state    <= BUSY_D;
            MemAddr  <= DataAddr;
            MemWData <= DataOut;
            MemRead  <= ~WriteData;
            MemWrite <= WriteData;
          end
        end
        BUSY_I, BUSY_D: begin
          if (MemReady) begin
            state    <= RESP;
            MemAddr  <= '0;
            MemWData <= '0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            if (state == BUSY_I) begin
              InstrIn   <= MemRData;
              InstrDone <= 1'b1;
            end else begin
              DataDone <= 1'b1;
              if (MemRead) begin
                DataIn <= MemRData;
              end
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Starvation expectations follow MEMARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

  logic        Clock;
  logic        Reset;
  logic        InstrReq;
  logic [15:0] InstrAddr;
  logic [15:0] InstrIn;
  logic        InstrDone;
  logic        ReadData;
  logic        WriteData;
  logic [15:0] DataAddr;
  logic [15:0] DataOut;
  logic [15:0] DataIn;
  logic        DataDone;
  logic [15:0] MemAddr;
  logic [15:0] MemWData;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] MemRData;
  logic        MemReady;

  mem_port_arbiter #(.WORD_SIZE(16), .STARVE_LIMIT(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .InstrReq(InstrReq), .InstrAddr(InstrAddr), .InstrIn(InstrIn), .InstrDone(InstrDone),
    .ReadData(ReadData), .WriteData(WriteData), .DataAddr(DataAddr), .DataOut(DataOut),
    .DataIn(DataIn), .DataDone(DataDone),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemRData(MemRData), .MemReady(MemReady)
  );

  typedef struct {
    logic        instr;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          waits;
    logic        exp_read;
    logic        exp_write;
    logic [15:0] exp_out;
  } vec_t;

  typedef struct {
    logic        instr;
    logic [15:0] data;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    if (InstrDone || DataDone) begin
      sb_t e;
      check("done_exclusive", {31'd0, InstrDone & DataDone}, 32'd0);
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_done_kind", {31'd0, InstrDone}, {31'd0, e.instr});
        check("sb_data", {16'd0, (e.instr ? InstrIn : DataIn)}, {16'd0, e.data});
      end
    end
  end

  task automatic run_txn(input vec_t v);
    sb_t e;
    InstrReq  = v.instr;
    InstrAddr = v.instr ? v.addr : 16'h0000;
    ReadData  = v.rd;
    WriteData = v.wr;
    DataAddr  = v.instr ? 16'h0000 : v.addr;
    DataOut   = v.wdata;
    MemRData  = v.rdata;
    MemReady  = 1'b1;
    e.instr = v.instr;
    e.data  = v.exp_out;
    sb.push_back(e);
    for (int j = 1; j <= v.waits + 1; j++) begin
      @(negedge Clock);
      check("busy_read", {31'd0, MemRead}, {31'd0, v.exp_read});
      check("busy_write", {31'd0, MemWrite}, {31'd0, v.exp_write});
      check("busy_addr", {16'd0, MemAddr}, {16'd0, v.addr});
      if (v.exp_write) check("busy_wdata", {16'd0, MemWData}, {16'd0, v.wdata});
      check("busy_no_done", {30'd0, InstrDone, DataDone}, 32'd0);
      InstrAddr = ~v.addr;
      DataAddr  = ~v.addr;
      DataOut   = ~v.wdata;
      MemReady  = (j == v.waits + 1);
    end
    @(negedge Clock);
    check("resp_done", {30'd0, InstrDone, DataDone}, v.instr ? 32'd2 : 32'd1);
    check("resp_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    InstrReq  = 1'b0;
    ReadData  = 1'b0;
    WriteData = 1'b0;
    MemReady  = 1'b1;
    @(negedge Clock);
    check("idle_done", {30'd0, InstrDone, DataDone}, 32'd0);
    check("idle_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    MemReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ex_i;
    int   dd_cyc;
    int   id_cyc;
    int   n_ig;

    //          instr rd   wr   addr      wdata     rdata     waits rd   wr   exp_out
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA5A5, 0, 1'b1, 1'b0, 16'hA5A5};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0020, 16'h1234, 16'hDEAD, 3, 1'b0, 1'b1, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5A5A, 1, 1'b1, 1'b0, 16'h5A5A};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 16'h1111, 0, 1'b0, 1'b1, 16'h5A5A};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0011, 16'h0000, 16'h0F0F, 2, 1'b1, 1'b0, 16'h0F0F};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 1'b1, 1'b0, 16'hFFFF};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h2222, 1, 1'b0, 1'b1, 16'hFFFF};

    Reset = 1'b1; InstrReq = 1'b0; InstrAddr = '0; ReadData = 1'b0; WriteData = 1'b0;
    DataAddr = '0; DataOut = '0; MemRData = '0; MemReady = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check("rst_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    check("rst_done", {30'd0, InstrDone, DataDone}, 32'd0);
    check("rst_mem_bus", {MemAddr, MemWData}, 32'd0);
    check("rst_read_bus", {InstrIn, DataIn}, 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Reset during the second wait cycle of a data read.
    ReadData = 1'b1; DataAddr = 16'h0500; MemRData = 16'h9999; MemReady = 1'b0;
    @(negedge Clock);
    check("rstmid_busy", {31'd0, MemRead}, 32'd1);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("rstmid_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
    check("rstmid_done", {30'd0, InstrDone, DataDone}, 32'd0);
    check("rstmid_mem_bus", {MemAddr, MemWData}, 32'd0);
    check("rstmid_read_bus", {InstrIn, DataIn}, 32'd0);
    @(negedge Clock);
    ReadData = 1'b0; MemReady = 1'b1;
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      check("rstmid_no_done", {31'd0, DataDone}, 32'd0);
    end
    MemReady = 1'b0;
    run_txn('{1'b1, 1'b0, 1'b0, 16'h0600, 16'h0000, 16'h3C3C, 1, 1'b1, 1'b0, 16'h3C3C});

    // Simultaneous fetch and data read: data first, fetch three cycles later.
    InstrReq = 1'b1; InstrAddr = 16'h0100; ReadData = 1'b1; DataAddr = 16'h0200;
    MemRData = 16'h7777; MemReady = 1'b1;
    sb.push_back('{1'b0, 16'h7777});
    sb.push_back('{1'b1, 16'h8888});
    dd_cyc = -100; id_cyc = 0;
    @(negedge Clock);
    check("prio_first_addr", {15'd0, MemRead, MemAddr}, {15'd0, 1'b1, 16'h0200});
    @(negedge Clock);
    if (DataDone) dd_cyc = cyc;
    ReadData = 1'b0; MemRData = 16'h8888;
    @(negedge Clock);
    check("prio_idle", {30'd0, MemRead, MemWrite}, 32'd0);
    @(negedge Clock);
    check("prio_second_addr", {15'd0, MemRead, MemAddr}, {15'd0, 1'b1, 16'h0100});
    @(negedge Clock);
    if (InstrDone) id_cyc = cyc;
    InstrReq = 1'b0;
    check("prio_gap", id_cyc - dd_cyc, 32'd3);
    @(negedge Clock);

    // Both requesters held; each re-raises right after its done pulse.
    n_ig = 0;
    InstrAddr = 16'h0300; DataAddr = 16'h0400;
    for (int g = 0; g < 10; g++) begin
`ifdef MEMARB_STARVE_GUARD_EN
      ex_i = ((g % 5) == 4);
`else
      ex_i = 1'b0;
`endif
      if (ex_i) n_ig++;
      sb.push_back('{ex_i, 16'(16'h5000 + g)});
      InstrReq = 1'b1; ReadData = 1'b1;
      MemRData = 16'(16'h5000 + g); MemReady = 1'b1;
      @(negedge Clock);
      check("starve_grant_addr", {16'd0, MemAddr}, ex_i ? 32'h0300 : 32'h0400);
      @(negedge Clock);
      check("starve_done", {30'd0, InstrDone, DataDone}, ex_i ? 32'd2 : 32'd1);
      if (ex_i) InstrReq = 1'b0;
      else ReadData = 1'b0;
      @(negedge Clock);
    end
    InstrReq = 1'b0; ReadData = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
